// File: rtl/lockable_reg_bank_pkg.sv
// Shared types and defaults for the lockable register bank.
// Debug-unlock support is enabled by defining LOCKABLE_REG_BANK_DBG_UNLOCK_EN.
package lockable_reg_bank_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE    = 2'd0,
    DBG_CHECK   = 2'd1,
    DBG_OPEN    = 2'd2,
    DBG_LOCKOUT = 2'd3
  } dbg_state_e;

  localparam logic [15:0] DBG_KEY_DEFAULT    = 16'hA5C3;
  localparam int          DBG_WINDOW_DEFAULT = 16;

endpackage

// File: rtl/lrb_channel.sv
// One lockable data channel: data register, sticky lock and blocked-write flag.
// The bypass input lets writes land on a locked channel (debug window).
module lrb_channel
  import lockable_reg_bank_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_req,
  input  logic              bypass,
  output logic [DATA_W-1:0] data,
  output logic              locked,
  output logic              viol,
  output logic              viol_hit
);

  logic [DATA_W-1:0] data_r;
  logic              locked_r;
  logic              viol_r;
  logic              write_ok_s;
  logic              viol_hit_s;

  // Decide whether this cycle's write lands or is a violation
  always_comb begin
    write_ok_s = wr_en & (~locked_r | bypass);
    viol_hit_s = wr_en & locked_r & ~bypass;
  end

  // Channel state; the lock only ever sets, reset is the sole way out
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= {DATA_W{1'b0}};
      locked_r <= 1'b0;
      viol_r   <= 1'b0;
    end else begin
      if (write_ok_s) begin
        data_r <= wr_data;
      end else begin
        data_r <= data_r;
      end
      locked_r <= locked_r | lock_req;
      viol_r   <= viol_hit_s;
    end
  end

  assign data     = data_r;
  assign locked   = locked_r;
  assign viol     = viol_r;
  assign viol_hit = viol_hit_s;

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of NUM_CH lockable registers with a saturating violation counter.
// Define LOCKABLE_REG_BANK_DBG_UNLOCK_EN to add the keyed debug-unlock FSM and its ports.
module lockable_reg_bank
  import lockable_reg_bank_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_W     = 16,
  parameter int          CNT_W      = 8,
  parameter int          DBG_WINDOW = DBG_WINDOW_DEFAULT,
  parameter logic [15:0] DBG_KEY    = DBG_KEY_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]        lock_req,
`ifdef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
  input  logic                     dbg_req,
  input  logic [15:0]              dbg_key,
  output logic                     dbg_open,
`endif
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        lock_status,
  output logic [NUM_CH-1:0]        viol_pulse,
  output logic [CNT_W-1:0]         viol_count
);

  if (NUM_CH < 1 || NUM_CH > 16 || DBG_WINDOW < 1 || $bits(DBG_KEY) != 16) begin : g_bad_cfg
    $error("lockable_reg_bank: unsupported parameter set");
  end

  logic [NUM_CH-1:0] hit_s;
  logic              bypass_s;
  logic [CNT_W+4:0]  sum_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W-1:0]  viol_count_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lrb_channel #(.DATA_W(DATA_W)) u_ch (
      .clk      (Clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (wr_data[i*DATA_W +: DATA_W]),
      .lock_req (lock_req[i]),
      .bypass   (bypass_s),
      .data     (data_out[i*DATA_W +: DATA_W]),
      .locked   (lock_status[i]),
      .viol     (viol_pulse[i]),
      .viol_hit (hit_s[i])
    );
  end

  // Add this cycle's violations in a widened sum, then clamp to all-ones
  always_comb begin
    sum_s = {5'b00000, viol_count_r};
    for (int i = 0; i < NUM_CH; i++) begin
      sum_s = sum_s + {{(CNT_W+4){1'b0}}, hit_s[i]};
    end
    if (sum_s > {5'b00000, {CNT_W{1'b1}}}) begin
      count_next_s = {CNT_W{1'b1}};
    end else begin
      count_next_s = sum_s[CNT_W-1:0];
    end
  end

  // Violation counter, updated on the same edge as viol_pulse
  always_ff @(posedge Clk) begin
    if (rst) begin
      viol_count_r <= {CNT_W{1'b0}};
    end else begin
      viol_count_r <= count_next_s;
    end
  end

  assign viol_count = viol_count_r;

`ifdef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
  localparam int WIN_W = $clog2(DBG_WINDOW + 1);

  dbg_state_e       state_r;
  logic [15:0]      key_r;
  logic [WIN_W-1:0] win_r;
  logic             dbg_open_r;

  // Debug-unlock FSM; dbg_open is registered alongside the OPEN state
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_r    <= DBG_IDLE;
      key_r      <= 16'h0000;
      win_r      <= {WIN_W{1'b0}};
      dbg_open_r <= 1'b0;
    end else begin
      case (state_r)
        DBG_IDLE: begin
          if (dbg_req) begin
            state_r <= DBG_CHECK;
            key_r   <= dbg_key;
          end
        end
        DBG_CHECK: begin
          if (key_r == DBG_KEY) begin
            state_r    <= DBG_OPEN;
            win_r      <= WIN_W'(DBG_WINDOW - 1);
            dbg_open_r <= 1'b1;
          end else begin
            state_r <= DBG_LOCKOUT;
          end
        end
        DBG_OPEN: begin
          if (win_r == {WIN_W{1'b0}}) begin
            state_r    <= DBG_IDLE;
            dbg_open_r <= 1'b0;
          end else begin
            win_r <= win_r - {{(WIN_W-1){1'b0}}, 1'b1};
          end
        end
        DBG_LOCKOUT: begin
          state_r <= DBG_LOCKOUT;
        end
        default: begin
          state_r    <= DBG_LOCKOUT;
          dbg_open_r <= 1'b0;
        end
      endcase
    end
  end

  assign bypass_s = dbg_open_r;
  assign dbg_open = dbg_open_r;
`else
  assign bypass_s = 1'b0;
`endif

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Self-checking bench for lockable_reg_bank (NUM_CH=2, DATA_W=16, CNT_W=8).
// Debug-unlock scenarios run when LOCKABLE_REG_BANK_DBG_UNLOCK_EN is defined.
module tb_lockable_reg_bank;

  logic        Clk;
  logic        rst;
  logic [1:0]  wr_en;
  logic [31:0] wr_data;
  logic [1:0]  lock_req;
  logic        dbg_req;
  logic [15:0] dbg_key;
  logic        dbg_open_w;
  logic [31:0] data_out;
  logic [1:0]  lock_status;
  logic [1:0]  viol_pulse;
  logic [7:0]  viol_count;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  lockable_reg_bank #(.NUM_CH(2), .DATA_W(16), .CNT_W(8)) dut (
    .Clk         (Clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .lock_req    (lock_req),
`ifdef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
    .dbg_req     (dbg_req),
    .dbg_key     (dbg_key),
    .dbg_open    (dbg_open_w),
`endif
    .data_out    (data_out),
    .lock_status (lock_status),
    .viol_pulse  (viol_pulse),
    .viol_count  (viol_count)
  );

`ifndef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
  assign dbg_open_w = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: per-channel arrays, an integer counter and a debug window countdown
  logic [15:0] m_data [2];
  bit          m_lock [2];
  bit          m_viol [2];
  int          m_cnt;
  int          m_open_left;
  bit          m_checking;
  bit          m_lockout;
  logic [15:0] m_key;

  always @(posedge Clk) begin
    int  n;
    bit  open_now;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_data[i] = 16'h0000; m_lock[i] = 1'b0; m_viol[i] = 1'b0;
      end
      m_cnt = 0; m_open_left = 0; m_checking = 1'b0; m_lockout = 1'b0;
    end else begin
      open_now = (m_open_left > 0);
      n = 0;
      for (int i = 0; i < 2; i++) begin
        m_viol[i] = 1'b0;
        if (wr_en[i]) begin
          if (!m_lock[i] || open_now) m_data[i] = wr_data[i*16 +: 16];
          else begin m_viol[i] = 1'b1; n++; end
        end
        if (lock_req[i]) m_lock[i] = 1'b1;
      end
      m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
`ifdef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
      if (m_open_left > 0) m_open_left--;
      else if (m_checking) begin
        m_checking = 1'b0;
        if (m_key == 16'hA5C3) m_open_left = 16;
        else m_lockout = 1'b1;
      end else if (!m_lockout && dbg_req) begin
        m_checking = 1'b1; m_key = dbg_key;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (started) begin
      check("model data_out", data_out, {m_data[1], m_data[0]});
      check("model lock_status", {30'd0, lock_status}, {30'd0, m_lock[1], m_lock[0]});
      check("model viol_pulse", {30'd0, viol_pulse}, {30'd0, m_viol[1], m_viol[0]});
      check("model viol_count", {24'd0, viol_count}, m_cnt);
      check("model dbg_open", {31'd0, dbg_open_w}, {31'd0, (m_open_left > 0)});
    end
  end

  task automatic step(input logic [1:0] we, input logic [31:0] wd, input logic [1:0] lr,
                      input logic r, input logic rq, input logic [15:0] k);
    wr_en = we; wr_data = wd; lock_req = lr; rst = r; dbg_req = rq; dbg_key = k;
    @(posedge Clk);
    @(negedge Clk);
    wr_en = 2'b00; lock_req = 2'b00; rst = 1'b0; dbg_req = 1'b0; dbg_key = 16'h0000;
  endtask

  initial begin
    int n;
    wr_en = 2'b00; wr_data = 32'h0; lock_req = 2'b00; rst = 1'b1; dbg_req = 1'b0; dbg_key = 16'h0;
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    started = 1'b1;
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    check("reset data_out", data_out, 32'h0);
    check("reset lock_status", {30'd0, lock_status}, 32'd0);
    check("reset viol_count", {24'd0, viol_count}, 32'd0);

    // Write then lock ch0, then a blocked write
    step(2'b01, 32'h0000_1234, 2'b00, 1'b0, 1'b0, 16'h0);
    step(2'b00, 32'h0, 2'b01, 1'b0, 1'b0, 16'h0);
    check("ch0 written", {16'd0, data_out[15:0]}, 32'h1234);
    check("ch0 locked", {30'd0, lock_status}, 32'd1);
    step(2'b01, 32'h0000_FFFF, 2'b00, 1'b0, 1'b0, 16'h0);
    check("blocked data held", {16'd0, data_out[15:0]}, 32'h1234);
    check("viol pulse", {30'd0, viol_pulse}, 32'd1);
    check("viol count 1", {24'd0, viol_count}, 32'd1);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    check("viol pulse one cycle", {30'd0, viol_pulse}, 32'd0);

    // Simultaneous write+lock on both channels, then dual violation
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    step(2'b11, 32'h5555_AAAA, 2'b11, 1'b0, 1'b0, 16'h0);
    check("dual write", data_out, 32'h5555_AAAA);
    check("dual lock", {30'd0, lock_status}, 32'd3);
    step(2'b11, 32'h1111_2222, 2'b00, 1'b0, 1'b0, 16'h0);
    check("dual viol count", {24'd0, viol_count}, 32'd2);
    check("dual viol pulse", {30'd0, viol_pulse}, 32'd3);

    // Saturation
    for (int i = 0; i < 300; i++) step(2'b10, 32'hDEAD_0000, 2'b00, 1'b0, 1'b0, 16'h0);
    check("saturated", {24'd0, viol_count}, 32'hFF);
    step(2'b11, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    check("saturated holds", {24'd0, viol_count}, 32'hFF);

    // Reset with both locked clears everything
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    check("rst clears data", data_out, 32'h0);
    check("rst clears lock", {30'd0, lock_status}, 32'd0);
    check("rst clears count", {24'd0, viol_count}, 32'd0);

    // Channel independence: ch1 locked, ch0 free
    step(2'b10, 32'h7777_0000, 2'b10, 1'b0, 1'b0, 16'h0);
    step(2'b11, 32'h9999_4321, 2'b00, 1'b0, 1'b0, 16'h0);
    check("indep data", data_out, 32'h7777_4321);
    check("indep pulse", {30'd0, viol_pulse}, 32'd2);

`ifdef LOCKABLE_REG_BANK_DBG_UNLOCK_EN
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    step(2'b01, 32'h0000_1234, 2'b01, 1'b0, 1'b0, 16'h0);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 16'hA5C3);
    check("dbg check not open", {31'd0, dbg_open_w}, 32'd0);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    check("dbg open", {31'd0, dbg_open_w}, 32'd1);
    step(2'b01, 32'h0000_BEEF, 2'b00, 1'b0, 1'b0, 16'h0);
    check("dbg write lands", {16'd0, data_out[15:0]}, 32'hBEEF);
    check("dbg no viol", {30'd0, viol_pulse}, 32'd0);
    check("dbg lock kept", {30'd0, lock_status}, 32'd1);
    n = 2;
    for (int i = 0; i < 40 && dbg_open_w; i++) begin
      step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
      if (dbg_open_w) n++;
    end
    check("dbg window length", n, 32'd16);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 16'h0000);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 16'hA5C3);
    for (int i = 0; i < 4; i++) step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    check("lockout stays closed", {31'd0, dbg_open_w}, 32'd0);
    step(2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 16'h0);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 16'hA5C3);
    step(2'b11, 32'h5555_AAAA, 2'b11, 1'b0, 1'b0, 16'h0);
    check("reopen after rst", {31'd0, dbg_open_w}, 32'd1);
    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    step(2'b11, 32'h1234_5678, 2'b00, 1'b1, 1'b0, 16'h0);
    check("mid-open rst data", data_out, 32'h0);
    check("mid-open rst lock", {30'd0, lock_status}, 32'd0);
    check("mid-open rst open", {31'd0, dbg_open_w}, 32'd0);
`endif

    step(2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
